mux_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4:1 channel mux. It drives the mux select lines `s1`/`s0` through the enabled channels, waits a programmable settle time on each, and samples the mux output `y`. It then delivers the four captured bits as one parallel word with a start/done handshake. Downstream logic gets a coherent snapshot of all four mux inputs through the single-bit mux path.

---
 rtl/mux_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Walks a 4:1 mux through its enabled channels and samples each
//               one after a settle delay. Delivers the captured word with a
//               start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       done,
  output logic [3:0] data
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SETTLE = 2'd1;
  localparam logic [1:0] c_ST_SAMPLE = 2'd2;
  localparam logic [1:0] c_ST_DONE   = 2'd3;
  localparam logic [3:0] c_CNT_LAST  = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle time a new channel goes straight to its sample cycle.
  localparam logic [1:0] c_ST_ENTRY  = (SETTLE == 0) ? c_ST_SAMPLE : c_ST_SETTLE;

  logic [1:0] r_state;
  logic [3:0] r_mask;
  logic [3:0] r_shadow;
  logic [3:0] r_cnt;
  logic [1:0] r_sel;
  logic [3:0] r_data;

  logic [1:0] w_state_nx;
  logic [3:0] w_mask_nx;
  logic [3:0] w_shadow_nx;
  logic [3:0] w_cnt_nx;
  logic [1:0] w_sel_nx;
  logic [3:0] w_data_nx;
  logic [1:0] w_first;
  logic [1:0] w_next;
  logic       w_has_next;

  // Lowest enabled channel of the incoming mask, and the next enabled one above the current select.
  always_comb begin
    w_first    = 2'd0;
    w_next     = 2'd0;
    w_has_next = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) begin
        w_first = 2'(k);
      end
      if (r_mask[k] && (2'(k) > r_sel)) begin
        w_has_next = 1'b1;
        w_next     = 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_ST_IDLE;
      r_mask   <= 4'd0;
      r_shadow <= 4'd0;
      r_cnt    <= 4'd0;
      r_sel    <= 2'd0;
      r_data   <= 4'd0;
    end else begin
      r_state  <= w_state_nx;
      r_mask   <= w_mask_nx;
      r_shadow <= w_shadow_nx;
      r_cnt    <= w_cnt_nx;
      r_sel    <= w_sel_nx;
      r_data   <= w_data_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_mask_nx   = r_mask;
    w_shadow_nx = r_shadow;
    w_cnt_nx    = r_cnt;
    w_sel_nx    = r_sel;
    w_data_nx   = r_data;
    case (r_state)
      c_ST_IDLE, c_ST_DONE: begin
        w_state_nx = c_ST_IDLE;
        if (start) begin
          w_mask_nx   = mask;
          w_shadow_nx = 4'd0;
          w_cnt_nx    = 4'd0;
          if (mask == 4'd0) begin
            w_state_nx = c_ST_DONE;
            w_data_nx  = 4'd0;
          end else begin
            w_state_nx = c_ST_ENTRY;
            w_sel_nx   = w_first;
          end
        end
      end
      c_ST_SETTLE: begin
        if (r_cnt == c_CNT_LAST) begin
          w_state_nx = c_ST_SAMPLE;
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      c_ST_SAMPLE: begin
        w_shadow_nx[r_sel] = y;
        if (w_has_next) begin
          w_sel_nx   = w_next;
          w_cnt_nx   = 4'd0;
          w_state_nx = c_ST_ENTRY;
        end else begin
          w_state_nx = c_ST_DONE;
          w_data_nx  = w_shadow_nx;
        end
      end
      default: begin
        w_state_nx = c_ST_IDLE;
      end
    endcase
  end

  always_comb begin
    s1   = r_sel[1];
    s0   = r_sel[0];
    busy = (r_state == c_ST_SETTLE) || (r_state == c_ST_SAMPLE);
    done = (r_state == c_ST_DONE);
    data = r_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Random and directed stimulus for two scanners (SETTLE=2 and
//               SETTLE=0) sharing one 4:1 mux input set; scoreboard checking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] mask;
  logic [3:0] i_in;

  logic [1:0] d_s1, d_s0, d_busy, d_done, d_y;
  logic [3:0] d_data [2];

  always #5 clk = ~clk;

  assign d_y[0] = i_in[{d_s1[0], d_s0[0]}];
  assign d_y[1] = i_in[{d_s1[1], d_s0[1]}];

  mux_scan_ctrl #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .y(d_y[0]),
    .s1(d_s1[0]), .s0(d_s0[0]), .busy(d_busy[0]), .done(d_done[0]), .data(d_data[0])
  );

  mux_scan_ctrl #(.SETTLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .y(d_y[1]),
    .s1(d_s1[1]), .s0(d_s0[1]), .busy(d_busy[1]), .done(d_done[1]), .data(d_data[1])
  );

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [3:0] hist [4096];
  int         e0_q [2][256];
  logic [3:0] m_q  [2][256];
  int         wr [2] = '{0, 0};
  int         rd [2] = '{0, 0};
  bit         have [2];
  int         cur_e0 [2];
  logic [3:0] cur_m [2];
  int         prev_hold [2];
  logic [3:0] m_data [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int nth_en(input logic [3:0] m, input int n);
    int c = 0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        if (c == n) return k;
        c++;
      end
    end
    return 0;
  endfunction

  function automatic int highest(input logic [3:0] m);
    int h = 0;
    for (int k = 0; k < 4; k++) if (m[k]) h = k;
    return h;
  endfunction

  function automatic int end_of(input int s, input int e0, input logic [3:0] m);
    return e0 + $countones(m) * (s + 1);
  endfunction

  // Channel j (in ascending order) is captured at the close of its (s+1)-cycle slot.
  function automatic logic [3:0] exp_data(input int s, input int e0, input logic [3:0] m);
    logic [3:0] d = 4'd0;
    int j = 0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        j++;
        d[k] = hist[(e0 + j * (s + 1)) % 4096][k];
      end
    end
    return d;
  endfunction

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d: got %0d expected %0d", nm, inst, cyc, act, exp);
    end
  endtask

  // Reference model: decides acceptance at each edge and queues the expected scan.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          have[i] = 1'b0; prev_hold[i] = 0; cur_m[i] = 4'd0; cur_e0[i] = 0;
        end
      end else begin
        cyc++;
        hist[cyc % 4096] = i_in;
        for (int i = 0; i < 2; i++) begin
          if (start && (!have[i] || cyc > end_of(settle_of(i), cur_e0[i], cur_m[i]))) begin
            if (have[i] && cur_m[i] != 4'd0) prev_hold[i] = highest(cur_m[i]);
            have[i]   = 1'b1;
            cur_e0[i] = cyc;
            cur_m[i]  = mask;
            e0_q[i][wr[i] % 256] = cyc;
            m_q[i][wr[i] % 256]  = mask;
            wr[i]++;
          end
        end
      end
    end
  end

  // Monitor: per-cycle expectations plus scoreboard pop on every done pulse.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          rd[i] = wr[i];
          m_data[i] = 4'd0;
        end else begin
          int s, eb, ed, es, en, pe, pend;
          logic [3:0] pm;
          s  = settle_of(i);
          eb = 0; ed = 0; es = prev_hold[i];
          if (have[i]) begin
            en = end_of(s, cur_e0[i], cur_m[i]);
            if (cyc < en) begin
              eb = 1;
              es = nth_en(cur_m[i], (cyc - cur_e0[i]) / (s + 1));
            end else begin
              if (cur_m[i] != 4'd0) es = highest(cur_m[i]);
              if (cyc == en) begin
                ed = 1;
                m_data[i] = exp_data(s, cur_e0[i], cur_m[i]);
              end
            end
          end
          chk("busy", i, d_busy[i], eb);
          chk("done", i, d_done[i], ed);
          chk("sel", i, {d_s1[i], d_s0[i]}, es);
          chk("data", i, d_data[i], m_data[i]);
          if (d_done[i]) begin
            if (rd[i] == wr[i]) begin
              chk("sb_unexpected_done", i, 1, 0);
            end else begin
              pe   = e0_q[i][rd[i] % 256];
              pm   = m_q[i][rd[i] % 256];
              pend = end_of(s, pe, pm);
              rd[i]++;
              chk("sb_done_time", i, cyc, pend);
              chk("sb_data", i, d_data[i], exp_data(s, pe, pm));
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [3:0] m);
    mask  = m;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_s1"}, i, d_s1[i], 0);
      chk({nm, "_s0"}, i, d_s0[i], 0);
      chk({nm, "_busy"}, i, d_busy[i], 0);
      chk({nm, "_done"}, i, d_done[i], 0);
      chk({nm, "_data"}, i, d_data[i], 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b0; mask = 4'd0; i_in = 4'd0;
    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Full scan: i0..i3 = 1,0,1,1
    i_in = 4'b1101;
    pulse_start(4'b1111);
    tick(14);
    chk("t1_data", 0, d_data[0], 4'b1101);
    chk("t1_data", 1, d_data[1], 4'b1101);

    pulse_start(4'b0101);
    tick(8);
    chk("t2_data", 0, d_data[0], 4'b0101);

    // Empty mask completes in the very next cycle
    pulse_start(4'b0000);
    chk("t3_done", 0, d_done[0], 1);
    chk("t3_done", 1, d_done[1], 1);
    chk("t3_data", 0, d_data[0], 0);
    chk("t3_busy", 0, d_busy[0], 0);
    tick(3);

    // Start held high: back-to-back scans
    mask  = 4'b1111;
    start = 1'b1;
    repeat (40) begin
      i_in = 4'($urandom);
      tick(1);
    end
    start = 1'b0;
    tick(14);

    // Reset during channel-2 settle
    i_in = 4'b1011;
    pulse_start(4'b1111);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (d_s1[0] && !d_s0[0] && d_busy[0]) found = 1'b1;
      else tick(1);
    end
    chk("ch2_reached", 0, found, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midscan_reset");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    pulse_start(4'b1111);
    tick(14);
    chk("after_reset_data", 0, d_data[0], 4'b1011);

    // Mask toggling mid-scan has no effect
    i_in = 4'b0110;
    pulse_start(4'b1111);
    repeat (3) begin
      mask = 4'($urandom);
      tick(1);
    end
    tick(12);
    chk("t6_data", 1, d_data[1], 4'b0110);
    chk("t6_data", 0, d_data[0], 4'b0110);

    // Random traffic
    repeat (400) begin
      start = ($urandom_range(0, 3) == 0);
      mask  = 4'($urandom);
      i_in  = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      tick(1);
    end
    start = 1'b0;
    tick(16);
    chk("sb_drain", 0, rd[0], wr[0]);
    chk("sb_drain", 1, rd[1], wr[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
